// File: rtl/digit_entry_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module : digit_entry_assembler_pkg
// Brief  : Shared quiz types and BCD helpers for the entry, display and
//          controller paths.
// Rev    : 1.0 - initial release
// ============================================================================
package digit_entry_assembler_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } entry_state_t;

    function automatic logic bcd_is_legal(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mac_step.sv
`default_nettype none
// ============================================================================
// Module : bcd_mac_step
// Brief  : Combinational decimal shift-in step: acc*10 + digit at ACC_W bits.
// Rev    : 1.0 - initial release
// ============================================================================
module bcd_mac_step #(
    parameter int ACC_W = 7
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [3:0]       i_digit,
    output logic [ACC_W-1:0] o_acc_next
);

    // The caller sizes ACC_W so that every legal partial entry times ten
    // plus a digit still fits without wrapping.
    assign o_acc_next = (i_acc * ACC_W'(10)) + ACC_W'(i_digit);

endmodule
`default_nettype wire

// File: rtl/digit_entry_assembler.sv
`default_nettype none
// ============================================================================
// Module : digit_entry_assembler
// Brief  : Collects keyed decimal digits (MSD first) into a saturated binary
//          answer and a right-aligned BCD display image.
// Rev    : 1.0 - initial release
// ============================================================================
module digit_entry_assembler
    import digit_entry_assembler_pkg::*;
#(
    parameter int MAX_DIGITS = 2,
    parameter int VALUE_W    = 4,
    parameter int MAX_VALUE  = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                digit_valid,
    input  logic [3:0]                          digit_in,
    input  logic                                submit,
    input  logic                                clear,
    output logic [4*MAX_DIGITS-1:0]             disp_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]     digit_count,
    output logic [VALUE_W-1:0]                  result,
    output logic                                result_valid,
    output logic                                result_ovf,
    output logic                                result_empty,
    output logic                                digit_err
);

    localparam int ACC_W = $clog2(10**MAX_DIGITS);
    localparam int CNT_W = $clog2(MAX_DIGITS+1);

    localparam logic [CNT_W-1:0]        c_max_cnt    = CNT_W'(MAX_DIGITS);
    localparam logic [31:0]             c_max_value  = 32'(MAX_VALUE);
    localparam logic [4*MAX_DIGITS-1:0] c_blank_disp = {MAX_DIGITS{BCD_BLANK}};

    entry_state_t              r_state;
    logic [ACC_W-1:0]          r_acc;
    logic [4*MAX_DIGITS-1:0]   r_disp;
    logic [CNT_W-1:0]          r_count;
    logic [VALUE_W-1:0]        r_result;
    logic                      r_result_valid;
    logic                      r_result_ovf;
    logic                      r_result_empty;
    logic                      r_digit_err;

    logic [ACC_W-1:0]          w_acc_next;
    logic [4*MAX_DIGITS-1:0]   w_disp_shift;
    logic [CNT_W-1:0]          w_count_inc;
    logic                      w_accept;

    bcd_mac_step #(
        .ACC_W      (ACC_W)
    ) u_mac (
        .i_acc      (r_acc),
        .i_digit    (digit_in),
        .o_acc_next (w_acc_next)
    );

    generate
        if (MAX_DIGITS == 1) begin : g_disp_single
            assign w_disp_shift = digit_in;
        end else begin : g_disp_multi
            assign w_disp_shift = {r_disp[4*MAX_DIGITS-5:0], digit_in};
        end
    endgenerate

    assign w_count_inc = r_count + CNT_W'(1);
    assign w_accept    = bcd_is_legal(digit_in) && (r_state != ST_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_EMPTY;
            r_acc          <= '0;
            r_disp         <= c_blank_disp;
            r_count        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_ovf   <= 1'b0;
            r_result_empty <= 1'b0;
            r_digit_err    <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_result_ovf   <= 1'b0;
            r_result_empty <= 1'b0;
            r_digit_err    <= 1'b0;

            if (clear) begin
                r_state <= ST_EMPTY;
                r_acc   <= '0;
                r_disp  <= c_blank_disp;
                r_count <= '0;
            end else if (submit) begin
                // A digit strobe coinciding with submit is dropped silently.
                r_result_valid <= 1'b1;
                if (r_state == ST_EMPTY) begin
                    r_result_empty <= 1'b1;
                    r_result       <= '0;
                end else if (32'(r_acc) > c_max_value) begin
                    r_result_ovf   <= 1'b1;
                    r_result       <= VALUE_W'(MAX_VALUE);
                end else begin
                    r_result       <= VALUE_W'(r_acc);
                end
                r_state <= ST_EMPTY;
                r_acc   <= '0;
                r_disp  <= c_blank_disp;
                r_count <= '0;
            end else if (digit_valid) begin
                if (w_accept) begin
                    r_acc   <= w_acc_next;
                    r_disp  <= w_disp_shift;
                    r_count <= w_count_inc;
                    r_state <= (w_count_inc == c_max_cnt) ? ST_FULL : ST_ENTRY;
                end else begin
                    r_digit_err <= 1'b1;
                end
            end
        end
    end

    assign disp_bcd     = r_disp;
    assign digit_count  = r_count;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign result_ovf   = r_result_ovf;
    assign result_empty = r_result_empty;
    assign digit_err    = r_digit_err;

endmodule
`default_nettype wire

// File: tb/tb_digit_entry_assembler.sv
`default_nettype none
// ============================================================================
// Module : tb_digit_entry_assembler
// Brief  : Scoreboard bench: a digit-list reference model queues expected
//          pulses, a negedge monitor compares them against the DUT.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_digit_entry_assembler;

    localparam int MAXD = 2;
    localparam int VW   = 4;
    localparam int MAXV = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            digit_valid;
    logic [3:0]      digit_in;
    logic            submit;
    logic            clear;
    logic [4*MAXD-1:0] disp_bcd;
    logic [1:0]      digit_count;
    logic [VW-1:0]   result;
    logic            result_valid;
    logic            result_ovf;
    logic            result_empty;
    logic            digit_err;

    always #5 clk = ~clk;

    digit_entry_assembler #(
        .MAX_DIGITS   (MAXD),
        .VALUE_W      (VW),
        .MAX_VALUE    (MAXV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .digit_valid  (digit_valid),
        .digit_in     (digit_in),
        .submit       (submit),
        .clear        (clear),
        .disp_bcd     (disp_bcd),
        .digit_count  (digit_count),
        .result       (result),
        .result_valid (result_valid),
        .result_ovf   (result_ovf),
        .result_empty (result_empty),
        .digit_err    (digit_err)
    );

    typedef struct {
        bit is_err;
        int res;
        bit ovf;
        bit empty;
    } ev_t;

    ev_t             exp_q[$];
    int              digits[$];
    logic [4*MAXD-1:0] exp_disp = '1;
    int              exp_count = 0;
    bit              mon_en = 1'b0;
    int              n_checks = 0;
    int              n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: the entry is just a list of digits; its value is plain decimal.
    task automatic model_update(input bit r, input bit c, input bit s, input bit v, input int d);
        ev_t e;
        int  val;
        if (r || c) begin
            digits.delete();
        end else if (s) begin
            e.is_err = 1'b0;
            e.ovf    = 1'b0;
            e.empty  = 1'b0;
            if (digits.size() == 0) begin
                e.empty = 1'b1;
                e.res   = 0;
            end else begin
                val = 0;
                foreach (digits[i]) val = val * 10 + digits[i];
                if (val > MAXV) begin
                    e.ovf = 1'b1;
                    e.res = MAXV;
                end else begin
                    e.res = val;
                end
            end
            exp_q.push_back(e);
            digits.delete();
        end else if (v) begin
            if (d <= 9 && digits.size() < MAXD) begin
                digits.push_back(d);
            end else begin
                e.is_err = 1'b1;
                e.res    = 0;
                e.ovf    = 1'b0;
                e.empty  = 1'b0;
                exp_q.push_back(e);
            end
        end
        exp_count = digits.size();
        for (int i = 0; i < MAXD; i++) begin
            if (i < digits.size()) exp_disp[4*i +: 4] = 4'(digits[digits.size()-1-i]);
            else                   exp_disp[4*i +: 4] = 4'hF;
        end
    endtask

    task automatic cycle(input bit r, input bit c, input bit s, input bit v, input int d);
        rst         = r;
        clear       = c;
        submit      = s;
        digit_valid = v;
        digit_in    = 4'(d);
        @(posedge clk);
        model_update(r, c, s, v, d);
        #1;
    endtask

    task automatic key(input int d); cycle(0, 0, 0, 1, d); endtask
    task automatic sub();            cycle(0, 0, 1, 0, 0); endtask
    task automatic clr();            cycle(0, 1, 0, 0, 0); endtask
    task automatic idle();           cycle(0, 0, 0, 0, 0); endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            chk("disp_bcd", 32'(disp_bcd), 32'(exp_disp));
            chk("digit_count", 32'(digit_count), 32'(exp_count));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.is_err) begin
                    chk("digit_err_pulse", 32'(digit_err), 32'd1);
                    chk("no_valid_on_err", 32'(result_valid), 32'd0);
                end else begin
                    chk("result_valid", 32'(result_valid), 32'd1);
                    chk("no_err_on_result", 32'(digit_err), 32'd0);
                    chk("result", 32'(result), 32'(e.res));
                    chk("result_ovf", 32'(result_ovf), 32'(e.ovf));
                    chk("result_empty", 32'(result_empty), 32'(e.empty));
                end
            end else begin
                chk("idle_valid", 32'(result_valid), 32'd0);
                chk("idle_err", 32'(digit_err), 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; submit = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_disp", 32'(disp_bcd), 32'hFF);
        chk("reset_count", 32'(digit_count), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", {28'd0, result_valid, result_ovf, result_empty, digit_err}, 32'd0);
        mon_en = 1'b1;

        key(1); key(2); sub(); idle();
        key(1); key(6); sub();
        key(0); key(9); sub();
        key(10);
        key(3); key(5); key(7); sub();
        key(7); clr(); sub();
        key(1); cycle(0, 0, 1, 1, 4); cycle(0, 1, 1, 0, 0);
        key(1); cycle(1, 0, 1, 0, 0);
        @(negedge clk);
        chk("mid_rst_result", 32'(result), 32'd0);
        key(9); sub(); sub(); idle();

        repeat (3000) begin
            bit r, c, s, v;
            int d;
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 5);
            s = ($urandom_range(0, 99) < 15);
            v = ($urandom_range(0, 99) < 55);
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            cycle(r, c, s, v, d);
        end

        idle(); idle(); idle();
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
